gpu_ingress_queue: RTL and testbench
====================================

# gpu_ingress_queue

GPU-side ingress buffer for a group-7 leaf router. It accepts flits and 6-bit destination addresses from the local GPU with a valid/ready handshake. It holds them in a FIFO and presents them, first-word-fall-through, to the leaf router's `gpu_in_data` / `gpu_in_valid` / `gpu_dest_addr` inputs. It also drives the router's GPU ingress FIFO status bits, supports a synchronous flush, and can optionally keep local/remote traffic counters.

## Interface
- `DWIDTH`, 16, flit data width.
- `FIFO_DEPTH`, 8, number of entries; power of two, at least 2.
- `GROUP_ID`, 4'b0111, this leaf's group; used to classify a destination as local or remote.
- `clk`  input  1  single clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `gpu_wr_data`  input  DWIDTH  flit from the GPU.
- `gpu_wr_dest`  input  6  destination address of that flit.
- `gpu_wr_valid`  input  1  GPU offers a flit.
- `gpu_wr_ready`  output  1  queue can accept; a push happens when valid && ready.
- `rtr_data`  output  DWIDTH  head flit; connects to the router's `gpu_in_data`.
- `rtr_dest_addr`  output  6  head destination; connects to `gpu_dest_addr`.
- `rtr_valid`  output  1  head is valid; connects to `gpu_in_valid`.
- `rtr_ready`  input  1  router consumes the head; a pop happens when valid && ready.
- `flush`  input  1  discard all queued entries.
- `fifo_full`  output  1  occupancy equals FIFO_DEPTH; drives `gpu_fifo_in_full`.
- `fifo_empty`  output  1  occupancy is 0; drives `gpu_fifo_in_empty`.
- `occupancy`  output  $clog2(FIFO_DEPTH)+1  current entry count.
- `local_count`  output  16  popped flits with `dest[5:2] == GROUP_ID` (stats only).
- `remote_count`  output  16  popped flits with `dest[5:2] != GROUP_ID` (stats only).

## Operation
- **Storage**
  - Each entry is DWIDTH+6 bits: {dest, data}.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - A separate occupancy counter is kept.
- **FSM states:** RUN, FLUSH.
  - RUN → FLUSH when `flush` = 1.
  - FLUSH stays in FLUSH while `flush` = 1.
  - FLUSH → RUN when `flush` = 0.
- **In RUN**
  - `gpu_wr_ready` = !fifo_full.
  - `rtr_valid` = !fifo_empty.
  - `rtr_data` / `rtr_dest_addr` = entry at the read pointer (combinational from registers).
- **In FLUSH**
  - `gpu_wr_ready` = 0 and `rtr_valid` = 0.
  - Pointers and occupancy are held at 0; no pushes or pops occur.
  - Stats counters are not changed.
- **Flush request:** on the edge where RUN samples `flush` = 1, pointers and occupancy clear to 0. Any handshake in that same cycle is ignored and not counted.
- **Push and pop in the same cycle:** occupancy is unchanged and both pointers advance.
  - Full: `gpu_wr_ready` = 0, so only a pop is possible.
  - Empty: `rtr_valid` = 0, so only a push is possible.
  - There is no bypass when empty.
- **Data stability:** while `rtr_valid` = 1 and `rtr_ready` = 0, `rtr_data` and `rtr_dest_addr` hold stable.
- **Stats:** on each pop, exactly one of `local_count` / `remote_count` increments, chosen by `dest[5:2] == GROUP_ID`. Both counters wrap at 16'hFFFF → 0.
- **Reset values**
  - State RUN; pointers and occupancy 0; counters 0.
  - `gpu_wr_ready` = 1, `rtr_valid` = 0, `fifo_empty` = 1, `fifo_full` = 0.
  - `rtr_data` and `rtr_dest_addr` = 0, because storage is cleared on reset.
- **Reset priority:** reset overrides everything, including an in-progress flush.

## Timing
- **Push-to-output latency:** a push on edge N into an empty queue gives `rtr_valid` = 1 in the cycle after edge N.
- **Throughput:** one push and one pop per cycle are sustainable indefinitely.
- **Status outputs:** `fifo_full`, `fifo_empty` and `occupancy` are registered and reflect the state after the most recent edge.
- **Full back-pressure:** a pop on edge N while full makes `gpu_wr_ready` = 1 in the following cycle; there is no same-cycle pass-through.
- **Flush recovery:** if `flush` is high for edges N..M, then `gpu_wr_ready` = 1 in the cycle after the first edge that samples `flush` = 0.

## Configuration
- **Macro:** `GPU_INGRESS_STATS_EN`.
- **Defined:** `local_count` and `remote_count` are implemented as described under Operation.
- **Undefined:**
  - The counter registers are omitted.
  - Both outputs are tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- **Basic FIFO order:** after reset, push flits 0x1111…0x3333 with dest 0x1C, 0x05, 0x1D, `rtr_ready` = 0.
  - `occupancy` = 3 and `rtr_data` = 0x1111 with `rtr_dest_addr` = 0x1C.
  - Raise `rtr_ready`: the three flits pop in order, then `fifo_empty` = 1.
  - With stats: `local_count` = 2, `remote_count` = 1.
- **Full back-pressure:** push 8 flits with `rtr_ready` = 0.
  - `fifo_full` = 1, `gpu_wr_ready` = 0, and a 9th valid flit is not accepted.
  - Pop 1: `gpu_wr_ready` = 1 in the next cycle.
- **Streaming and wrap:** continuous push and pop of 20 incrementing flits starting at 0x0100.
  - Occupancy stays constant.
  - Output sequence is 0x0100…0x0113 with no gaps after the first.
- **Flush mid-stream:** with 5 entries queued, assert `flush` for 3 cycles while `gpu_wr_valid` = 1.
  - `rtr_valid` = 0, `gpu_wr_ready` = 0, `occupancy` = 0.
  - After release, a new flit 0xBEEF is the head.
- **Reset mid-operation:** with 4 entries queued, assert `reset` for 1 cycle.
  - All outputs return to their reset values.
  - Counters read 0.

Source files
------------

// File: rtl/gpu_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module   : gpu_ingress_queue
// Purpose  : GPU-side ingress FIFO for a group-7 leaf router. Accepts
//            {dest, flit} pairs from the GPU with a valid/ready handshake and
//            presents them first-word-fall-through to the router's GPU port.
//            It also drives the router's ingress full/empty status bits and
//            supports a synchronous flush.
// Ports    : clk, reset                      - clock, sync active-high reset
//            gpu_wr_data/dest/valid/ready    - GPU write handshake
//            rtr_data/dest_addr/valid/ready  - head entry towards the router
//            flush                           - discard all queued entries
//            fifo_full, fifo_empty, occupancy- registered status
//            local_count, remote_count       - popped-flit statistics
// Config   : GPU_INGRESS_STATS_EN - when defined, implements local/remote pop
//            counters. When undefined, both count outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_ingress_queue #(
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] GROUP_ID   = 4'b0111
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DWIDTH-1:0]             gpu_wr_data,
    input  logic [5:0]                    gpu_wr_dest,
    input  logic                          gpu_wr_valid,
    output logic                          gpu_wr_ready,
    output logic [DWIDTH-1:0]             rtr_data,
    output logic [5:0]                    rtr_dest_addr,
    output logic                          rtr_valid,
    input  logic                          rtr_ready,
    input  logic                          flush,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [15:0]                   local_count,
    output logic [15:0]                   remote_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_OW = c_AW + 1;
    localparam int c_EW = DWIDTH + 6;

    localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
    localparam logic [c_OW-1:0] c_OCC_ONE  = 1;
    localparam logic [c_OW-1:0] c_OCC_FULL = c_OW'(FIFO_DEPTH);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_OW-1:0] r_occ;
    logic [c_OW-1:0] w_occ_nxt;
    logic            r_full;
    logic            r_empty;
    logic            w_run;
    logic            w_clear;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:   if (flush)  w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: if (!flush) w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    assign w_run = (r_state == c_ST_RUN);

    // The flush request edge and every FLUSH cycle force pointers/occupancy
    // to zero; a handshake coinciding with the request is dropped.
    assign w_clear = !w_run || flush;

    assign gpu_wr_ready = w_run && !r_full;
    assign rtr_valid    = w_run && !r_empty;

    assign w_push = gpu_wr_valid && gpu_wr_ready && !flush;
    assign w_pop  = rtr_valid && rtr_ready && !flush;

    // ------------------------------------------------------------------
    // Occupancy / pointers / status
    // ------------------------------------------------------------------
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_clear) begin
            w_occ_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + c_OCC_ONE;
        end else if (w_pop && !w_push) begin
            w_occ_nxt = r_occ - c_OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_occ   <= w_occ_nxt;
            // Status flags are registered from the next occupancy so they
            // track the count exactly after every edge.
            r_full  <= (w_occ_nxt == c_OCC_FULL);
            r_empty <= (w_occ_nxt == '0);
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {gpu_wr_dest, gpu_wr_data};
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rtr_data      = w_head[DWIDTH-1:0];
    assign rtr_dest_addr = w_head[c_EW-1:DWIDTH];
    assign fifo_full     = r_full;
    assign fifo_empty    = r_empty;
    assign occupancy     = r_occ;

    // ------------------------------------------------------------------
    // Optional pop statistics
    // ------------------------------------------------------------------
`ifdef GPU_INGRESS_STATS_EN
    logic [15:0] r_local_cnt;
    logic [15:0] r_remote_cnt;
    logic        w_is_local;

    // The upper four destination bits name the group.
    assign w_is_local = (w_head[c_EW-1:DWIDTH+2] == GROUP_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_local_cnt  <= 16'h0000;
            r_remote_cnt <= 16'h0000;
        end else if (w_pop) begin
            if (w_is_local) r_local_cnt  <= r_local_cnt + 16'h0001;
            else            r_remote_cnt <= r_remote_cnt + 16'h0001;
        end
    end

    assign local_count  = r_local_cnt;
    assign remote_count = r_remote_cnt;
`else
    assign local_count  = 16'h0000;
    assign remote_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpu_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_ingress_queue
// Purpose  : Self-checking bench for gpu_ingress_queue. A queue-based model
//            predicts every output each cycle; directed sequences add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_ingress_queue;

    localparam int         DWIDTH     = 16;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [3:0] GROUP_ID   = 4'b0111;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpu_wr_data;
    logic [5:0]  gpu_wr_dest;
    logic        gpu_wr_valid;
    logic        gpu_wr_ready;
    logic [15:0] rtr_data;
    logic [5:0]  rtr_dest_addr;
    logic        rtr_valid;
    logic        rtr_ready;
    logic        flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  occupancy;
    logic [15:0] local_count;
    logic [15:0] remote_count;

    int n_cmp = 0;
    int n_err = 0;

    gpu_ingress_queue #(
        .DWIDTH     (DWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GROUP_ID   (GROUP_ID)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .gpu_wr_data   (gpu_wr_data),
        .gpu_wr_dest   (gpu_wr_dest),
        .gpu_wr_valid  (gpu_wr_valid),
        .gpu_wr_ready  (gpu_wr_ready),
        .rtr_data      (rtr_data),
        .rtr_dest_addr (rtr_dest_addr),
        .rtr_valid     (rtr_valid),
        .rtr_ready     (rtr_ready),
        .flush         (flush),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .occupancy     (occupancy),
        .local_count   (local_count),
        .remote_count  (remote_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of {dest, data} plus a run/flush flag.
    // ------------------------------------------------------------------
    logic [21:0] m_q[$];
    bit          m_run = 1'b1;
    logic [15:0] m_lc  = 16'h0;
    logic [15:0] m_rc  = 16'h0;

    always @(posedge clk) begin
        logic [21:0] e;
        bit do_push, do_pop;
        if (reset) begin
            m_q.delete();
            m_run = 1'b1;
            m_lc  = 16'h0;
            m_rc  = 16'h0;
        end else if (m_run) begin
            if (flush) begin
                m_q.delete();
                m_run = 1'b0;
            end else begin
                do_pop  = (m_q.size() > 0) && rtr_ready;
                do_push = gpu_wr_valid && (m_q.size() < FIFO_DEPTH);
                if (do_pop) begin
                    e = m_q.pop_front();
                    if (e[21:18] == GROUP_ID) m_lc = m_lc + 16'h1;
                    else                      m_rc = m_rc + 16'h1;
                end
                if (do_push) m_q.push_back({gpu_wr_dest, gpu_wr_data});
            end
        end else if (!flush) begin
            m_run = 1'b1;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        int sz;
        sz = m_q.size();
        chk("m_ready", gpu_wr_ready, m_run && (sz < FIFO_DEPTH));
        chk("m_valid", rtr_valid, m_run && (sz > 0));
        chk("m_full",  fifo_full,  sz == FIFO_DEPTH);
        chk("m_empty", fifo_empty, sz == 0);
        chk("m_occ",   occupancy,  sz);
        if (sz > 0 && m_run) begin
            chk("m_data", rtr_data, m_q[0][15:0]);
            chk("m_dest", rtr_dest_addr, m_q[0][21:16]);
        end
`ifdef GPU_INGRESS_STATS_EN
        chk("m_lcnt", local_count, m_lc);
        chk("m_rcnt", remote_count, m_rc);
`else
        chk("m_lcnt", local_count, 16'h0);
        chk("m_rcnt", remote_count, 16'h0);
`endif
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [15:0] d, input logic [5:0] a);
        gpu_wr_valid = 1'b1;
        gpu_wr_data  = d;
        gpu_wr_dest  = a;
        step();
        gpu_wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rtr_ready = 1'b1;
        while (fifo_empty !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        rtr_ready = 1'b0;
        chk("drain_empty", fifo_empty, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, gpu_wr_ready, 1'b1);
        chk({tag, "_valid"}, rtr_valid, 1'b0);
        chk({tag, "_empty"}, fifo_empty, 1'b1);
        chk({tag, "_full"},  fifo_full, 1'b0);
        chk({tag, "_occ"},   occupancy, 4'd0);
        chk({tag, "_data"},  rtr_data, 16'h0000);
        chk({tag, "_dest"},  rtr_dest_addr, 6'h00);
        chk({tag, "_lcnt"},  local_count, 16'h0000);
        chk({tag, "_rcnt"},  remote_count, 16'h0000);
    endtask

    initial begin
        logic [15:0] d_tab [3];
        logic [5:0]  a_tab [3];
        d_tab = '{16'h1111, 16'h2222, 16'h3333};
        a_tab = '{6'h1C, 6'h05, 6'h1D};

        reset        = 1'b1;
        gpu_wr_data  = '0;
        gpu_wr_dest  = '0;
        gpu_wr_valid = 1'b0;
        rtr_ready    = 1'b0;
        flush        = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_reset_vals("rst");

        // Basic FIFO order
        for (int i = 0; i < 3; i++) push_one(d_tab[i], a_tab[i]);
        chk("t1_occ",  occupancy, 4'd3);
        chk("t1_head", rtr_data, 16'h1111);
        chk("t1_dest", rtr_dest_addr, 6'h1C);
        rtr_ready = 1'b1;
        step();
        chk("t1_pop1", rtr_data, 16'h2222);
        step();
        chk("t1_pop2", rtr_data, 16'h3333);
        step();
        chk("t1_empty", fifo_empty, 1'b1);
        rtr_ready = 1'b0;
`ifdef GPU_INGRESS_STATS_EN
        chk("t1_lcnt", local_count, 16'd2);
        chk("t1_rcnt", remote_count, 16'd1);
`else
        chk("t1_lcnt", local_count, 16'd0);
        chk("t1_rcnt", remote_count, 16'd0);
`endif

        // Full back-pressure
        for (int i = 0; i < 8; i++) push_one(16'hA000 + 16'(i), 6'(i));
        chk("t2_full",  fifo_full, 1'b1);
        chk("t2_ready", gpu_wr_ready, 1'b0);
        gpu_wr_valid = 1'b1;
        gpu_wr_data  = 16'hDEAD;
        gpu_wr_dest  = 6'h3F;
        step();
        chk("t2_no9th", occupancy, 4'd8);
        chk("t2_head",  rtr_data, 16'hA000);
        rtr_ready = 1'b1;
        step();
        gpu_wr_valid = 1'b0;
        rtr_ready    = 1'b0;
        chk("t2_ready_back", gpu_wr_ready, 1'b1);
        chk("t2_occ7", occupancy, 4'd7);
        chk("t2_head2", rtr_data, 16'hA001);
        drain();

        // Streaming with pointer wrap
        rtr_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            gpu_wr_valid = 1'b1;
            gpu_wr_data  = 16'h0100 + 16'(k);
            gpu_wr_dest  = 6'h1C;
            step();
            chk("t3_occ",   occupancy, 4'd1);
            chk("t3_valid", rtr_valid, 1'b1);
            chk("t3_data",  rtr_data, 16'h0100 + 16'(k));
        end
        gpu_wr_valid = 1'b0;
        step();
        chk("t3_empty", fifo_empty, 1'b1);
        rtr_ready = 1'b0;

        // Flush mid-stream
        for (int i = 0; i < 5; i++) push_one(16'hC000 + 16'(i), 6'h21);
        chk("t4_occ5", occupancy, 4'd5);
        flush        = 1'b1;
        gpu_wr_valid = 1'b1;
        gpu_wr_data  = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_valid", rtr_valid, 1'b0);
            chk("t4_ready", gpu_wr_ready, 1'b0);
            chk("t4_occ",   occupancy, 4'd0);
        end
        flush       = 1'b0;
        gpu_wr_data = 16'hBEEF;
        gpu_wr_dest = 6'h22;
        step();
        chk("t4_recover", gpu_wr_ready, 1'b1);
        chk("t4_novalid", rtr_valid, 1'b0);
        step();
        gpu_wr_valid = 1'b0;
        chk("t4_beef_v", rtr_valid, 1'b1);
        chk("t4_beef",   rtr_data, 16'hBEEF);
        chk("t4_beef_a", rtr_dest_addr, 6'h22);
        drain();

        // Reset mid-operation
        for (int i = 0; i < 4; i++) push_one(16'h7000 + 16'(i), 6'h1F);
        chk("t5_occ4", occupancy, 4'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("t5");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
